s_axi_mem: RTL and testbench

S_AXI_MEM -- requirements
Module: s_axi_mem

---
 rtl/s_axi_mem.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_s_axi_mem.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_axi_mem.sv
// s_axi_mem: AXI4 slave wrapping a word-wide byte-writable memory.
// Independent write (AW/W/B) and read (AR/R) engines, one outstanding
// INCR burst each. Malformed or out-of-window bursts complete normally on
// the bus but answer SLVERR, touch no memory and read back zeros.
module s_axi_mem #(
    parameter int                DWIDTH    = 32,
    parameter int                ID_WIDTH  = 1,
    parameter int                MEM_WORDS = 1024,
    parameter logic [DWIDTH-1:0] BASE      = '0
) (
    input  logic                  clk,
    input  logic                  xrst,
    // write address
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [DWIDTH-1:0]     awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    // write data
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DWIDTH-1:0]     wdata,
    input  logic [DWIDTH/8-1:0]   wstrb,
    input  logic                  wlast,
    // write response
    output logic                  bvalid,
    input  logic                  bready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    // read address
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [DWIDTH-1:0]     araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    // read data
    output logic                  rvalid,
    input  logic                  rready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DWIDTH-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast
);

    localparam int STRB_W = DWIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    // Wide enough that start + len*STRB_W + STRB_W-1 can never overflow.
    localparam int EW     = DWIDTH + 10;
    localparam logic [EW-1:0] LIMIT = EW'(BASE) + EW'(MEM_WORDS) * EW'(STRB_W) - EW'(1);

    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    // A burst is rejected if it is not INCR, not full-width, starts below
    // the window, or its last byte falls beyond the window.
    function automatic logic burst_err(input logic [DWIDTH-1:0] addr,
                                       input logic [7:0]        len,
                                       input logic [2:0]        size,
                                       input logic [1:0]        burst);
        logic [DWIDTH:0] diff;
        logic [EW-1:0]   last_byte;
        logic            below;
        diff      = {1'b0, addr} - {1'b0, BASE};
        below     = |(diff >> DWIDTH);
        last_byte = EW'(addr) + (EW'(len) << LSB) + EW'(STRB_W - 1);
        return (burst != INCR) || (size != 3'(LSB)) || below || (last_byte > LIMIT);
    endfunction

    // Word index of a byte address; upper bits drop so indices wrap.
    function automatic logic [IDX_W-1:0] word_idx(input logic [DWIDTH-1:0] addr);
        logic [DWIDTH-1:0] off;
        off = addr - BASE;
        return IDX_W'(off >> LSB);
    endfunction

    logic [DWIDTH-1:0] mem [MEM_WORDS];

    wstate_t w_state_q, w_state_d;
    rstate_t r_state_q, r_state_d;

    // write burst context
    logic [ID_WIDTH-1:0] wid_q,   wid_d;
    logic [IDX_W-1:0]    widx_q,  widx_d;
    logic [7:0]          wlen_q,  wlen_d;
    logic [8:0]          wcnt_q,  wcnt_d;
    logic                waerr_q, waerr_d;   // address/attribute error
    logic                wbad_q,  wbad_d;    // wlast disagreed with len
    logic                wover_q, wover_d;   // beats beyond len, not stored
    logic [1:0]          bresp_q, bresp_d;

    // read burst context
    logic [ID_WIDTH-1:0] rid_q,   rid_d;
    logic [IDX_W-1:0]    ridx_q,  ridx_d;
    logic [7:0]          rlen_q,  rlen_d;
    logic [8:0]          rcnt_q,  rcnt_d;
    logic                rerr_q,  rerr_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_err, ar_err;
    logic w_beat_last, r_beat_last;
    logic mem_we;
    logic [IDX_W-1:0]  rd_idx;
    logic [DWIDTH-1:0] mem_rd;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid  && wready;
    assign b_hs  = bvalid  && bready;
    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid  && rready;

    assign aw_err = burst_err(awaddr, awlen, awsize, awburst);
    assign ar_err = burst_err(araddr, arlen, arsize, arburst);

    assign w_beat_last = (wcnt_q == {1'b0, wlen_q});
    assign r_beat_last = (rcnt_q == {1'b0, rlen_q});

    assign mem_we = w_hs && !waerr_q && !wover_q;

    // While idle the first beat is fetched from the incoming address so it
    // is ready the cycle after AR; afterwards the prefetch pointer is used.
    assign rd_idx = (r_state_q == R_IDLE) ? word_idx(araddr) : ridx_q;
    assign mem_rd = mem[rd_idx];

    //------------------------------------------------------------------
    // Write FSM
    //------------------------------------------------------------------

    // Write state register
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) w_state_q <= W_IDLE;
        else      w_state_q <= w_state_d;
    end

    // Write next-state: address, data beats until wlast, then response
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs)          w_state_d = W_DATA;
            W_DATA:  if (w_hs && wlast)  w_state_d = W_RESP;
            W_RESP:  if (b_hs)           w_state_d = W_IDLE;
            default:                     w_state_d = W_IDLE;
        endcase
    end

    // Write channel handshake outputs follow the state directly
    always_comb begin
        awready = (w_state_q == W_IDLE);
        wready  = (w_state_q == W_DATA);
        bvalid  = (w_state_q == W_RESP);
    end

    // Write burst context: latch on AW, advance and track errors per beat
    always_comb begin
        wid_d   = wid_q;
        widx_d  = widx_q;
        wlen_d  = wlen_q;
        wcnt_d  = wcnt_q;
        waerr_d = waerr_q;
        wbad_d  = wbad_q;
        wover_d = wover_q;
        bresp_d = bresp_q;
        if (aw_hs) begin
            wid_d   = awid;
            widx_d  = word_idx(awaddr);
            wlen_d  = awlen;
            wcnt_d  = '0;
            waerr_d = aw_err;
            wbad_d  = 1'b0;
            wover_d = 1'b0;
        end else if (w_hs) begin
            widx_d = widx_q + IDX_W'(1);
            wcnt_d = wcnt_q + 9'd1;
            if (wlast != w_beat_last) wbad_d  = 1'b1;
            if (!wlast && w_beat_last) wover_d = 1'b1;
            if (wlast)
                bresp_d = (waerr_q || wbad_q || !w_beat_last) ? SLVERR : OKAY;
        end
    end

    // Write burst context registers
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            wid_q   <= '0;
            widx_q  <= '0;
            wlen_q  <= '0;
            wcnt_q  <= '0;
            waerr_q <= 1'b0;
            wbad_q  <= 1'b0;
            wover_q <= 1'b0;
            bresp_q <= OKAY;
        end else begin
            wid_q   <= wid_d;
            widx_q  <= widx_d;
            wlen_q  <= wlen_d;
            wcnt_q  <= wcnt_d;
            waerr_q <= waerr_d;
            wbad_q  <= wbad_d;
            wover_q <= wover_d;
            bresp_q <= bresp_d;
        end
    end

    assign bid   = wid_q;
    assign bresp = bresp_q;

    // Byte-enabled memory write; no reset so contents survive xrst
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) mem[widx_q][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    //------------------------------------------------------------------
    // Read FSM
    //------------------------------------------------------------------

    // Read state register
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) r_state_q <= R_IDLE;
        else      r_state_q <= r_state_d;
    end

    // Read next-state: stay in R_DATA until the beat with rlast is taken
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs)                r_state_d = R_DATA;
            R_DATA:  if (r_hs && r_beat_last)  r_state_d = R_IDLE;
            default:                           r_state_d = R_IDLE;
        endcase
    end

    // Read channel handshake outputs follow the state directly
    always_comb begin
        arready = (r_state_q == R_IDLE);
        rvalid  = (r_state_q == R_DATA);
        rlast   = (r_state_q == R_DATA) && r_beat_last;
    end

    // Read burst context: load first beat on AR, next beat on each R
    // handshake; memory is sampled before any same-edge write lands.
    always_comb begin
        rid_d   = rid_q;
        ridx_d  = ridx_q;
        rlen_d  = rlen_q;
        rcnt_d  = rcnt_q;
        rerr_d  = rerr_q;
        rresp_d = rresp_q;
        rdata_d = rdata_q;
        if (ar_hs) begin
            rid_d   = arid;
            rlen_d  = arlen;
            rcnt_d  = '0;
            rerr_d  = ar_err;
            rresp_d = ar_err ? SLVERR : OKAY;
            rdata_d = ar_err ? '0 : mem_rd;
            ridx_d  = rd_idx + IDX_W'(1);
        end else if (r_hs && !r_beat_last) begin
            rcnt_d  = rcnt_q + 9'd1;
            rdata_d = rerr_q ? '0 : mem_rd;
            ridx_d  = ridx_q + IDX_W'(1);
        end
    end

    // Read burst context registers
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            rid_q   <= '0;
            ridx_q  <= '0;
            rlen_q  <= '0;
            rcnt_q  <= '0;
            rerr_q  <= 1'b0;
            rresp_q <= OKAY;
            rdata_q <= '0;
        end else begin
            rid_q   <= rid_d;
            ridx_q  <= ridx_d;
            rlen_q  <= rlen_d;
            rcnt_q  <= rcnt_d;
            rerr_q  <= rerr_d;
            rresp_q <= rresp_d;
            rdata_q <= rdata_d;
        end
    end

    assign rid   = rid_q;
    assign rresp = rresp_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_s_axi_mem.sv
// Directed + randomized bench for s_axi_mem. A word-array model of the
// memory predicts read data and responses from the burst rules.
module tb_s_axi_mem;

    localparam int          MEM_W  = 1024;
    localparam logic [31:0] BASE_A = 32'h0;
    localparam longint      BASE_L = 0;

    logic        clk, xrst;
    logic        awvalid, awready, awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready, bid;
    logic [1:0]  bresp;
    logic        arvalid, arready, arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready, rid, rlast;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int ntests = 0;
    int nfail  = 0;

    logic [31:0] model [MEM_W];
    logic [31:0] wbuf  [512];
    logic [3:0]  sbuf  [512];
    logic [31:0] ebuf  [512];

    s_axi_mem #(.DWIDTH(32), .ID_WIDTH(1), .MEM_WORDS(MEM_W), .BASE(BASE_A)) dut (
        .clk(clk), .xrst(xrst),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected error flag straight from the burst rules (64-bit arithmetic).
    function automatic bit exp_err(input logic [31:0] addr, input int len,
                                   input logic [2:0] size, input logic [1:0] burst);
        longint first, last;
        first = longint'(addr);
        last  = first + longint'(len + 1) * 4 - 1;
        return (burst != 2'b01) || (size != 3'd2) || (first < BASE_L) ||
               (last > BASE_L + longint'(MEM_W) * 4 - 1);
    endfunction

    function automatic int wi(input logic [31:0] addr, input int i);
        return ((int'(addr - BASE_A) >>> 2) + i) % MEM_W;
    endfunction

    task automatic model_beat(input int w, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) model[w][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic aw_phase(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input logic id);
        int n; bit hs;
        awvalid = 1'b1; awaddr = addr; awlen = 8'(len); awsize = size;
        awburst = burst; awid = id;
        n = 0; hs = 1'b0;
        while (!hs && n < 64) begin
            @(negedge clk); hs = awready;
            @(posedge clk); #1; n++;
        end
        awvalid = 1'b0;
        check("aw_handshake", 64'(hs), 64'(1));
    endtask

    task automatic ar_phase(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input logic id);
        int n; bit hs;
        arvalid = 1'b1; araddr = addr; arlen = 8'(len); arsize = size;
        arburst = burst; arid = id;
        n = 0; hs = 1'b0;
        while (!hs && n < 64) begin
            @(negedge clk); hs = arready;
            @(posedge clk); #1; n++;
        end
        arvalid = 1'b0;
        check("ar_handshake", 64'(hs), 64'(1));
    endtask

    task automatic w_phase(input int nbeats, input int last_at, input bit rnd);
        for (int i = 0; i < nbeats; i++) begin
            int n; bit hs;
            if (rnd && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0; @(posedge clk); #1;
            end
            wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == last_at);
            n = 0; hs = 1'b0;
            while (!hs && n < 64) begin
                @(negedge clk); hs = wready;
                @(posedge clk); #1; n++;
            end
            check("w_handshake", 64'(hs), 64'(1));
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_phase(input logic id, input logic [1:0] resp, input bit rnd);
        int n; bit done, first;
        n = 0; done = 1'b0; first = 1'b1;
        while (!done && n < 4000) begin
            bready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (first) check("bvalid_after_wlast", 64'(bvalid), 64'(1));
            first = 1'b0;
            if (bvalid && bready) begin
                check("b_id", 64'(bid), 64'(id));
                check("b_resp", 64'(bresp), 64'(resp));
                done = 1'b1;
            end
            @(posedge clk); #1; n++;
        end
        bready = 1'b0;
        check("b_done", 64'(done), 64'(1));
        @(negedge clk);
        check("aw_reopen", 64'({awready, bvalid}), 64'(2'b10));
        @(posedge clk); #1;
    endtask

    task automatic r_phase(input int len, input logic id, input logic [1:0] resp, input bit rnd);
        int i, n; bit stalled; logic [34:0] held;
        i = 0; n = 0; stalled = 1'b0; held = '0;
        while (i <= len && n < 4000) begin
            rready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            check("r_valid", 64'(rvalid), 64'(1));
            if (stalled) check("r_hold", 64'({rdata, rlast, rresp}), 64'(held));
            if (rvalid && rready) begin
                check("r_data", 64'(rdata), 64'(ebuf[i]));
                check("r_last", 64'(rlast), 64'(i == len));
                check("r_resp", 64'(rresp), 64'(resp));
                check("r_id", 64'(rid), 64'(id));
                i++; stalled = 1'b0;
            end else begin
                stalled = 1'b1; held = {rdata, rlast, rresp};
            end
            @(posedge clk); #1; n++;
        end
        rready = 1'b0;
        check("r_count", 64'(i), 64'(len + 1));
        @(negedge clk);
        check("r_idle", 64'({rvalid, arready}), 64'(2'b01));
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input logic id, input bit rnd);
        bit err;
        err = exp_err(addr, len, size, burst);
        aw_phase(addr, len, size, burst, id);
        w_phase(len + 1, len, rnd);
        b_phase(id, err ? 2'b10 : 2'b00, rnd);
        if (!err) for (int i = 0; i <= len; i++) model_beat(wi(addr, i), wbuf[i], sbuf[i]);
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic id, input bit rnd);
        bit err;
        err = exp_err(addr, len, size, burst);
        for (int i = 0; i <= len; i++) ebuf[i] = err ? 32'h0 : model[wi(addr, i)];
        ar_phase(addr, len, size, burst, id);
        r_phase(len, id, err ? 2'b10 : 2'b00, rnd);
    endtask

    initial begin
        logic [31:0] a;
        int          ln;
        logic [1:0]  bt;
        logic [2:0]  sz;
        logic        idv;

        xrst = 1'b1;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 64'({awready, arready, wready, bvalid, rvalid, rlast}), 64'(6'b110000));
        check("reset_regs", 64'({bresp, rresp, bid, rid, rdata}), 64'(0));
        @(posedge clk); #1;
        xrst = 1'b0;

        // Write 1..256 at 0x0, read back, rlast only on beat 256
        for (int i = 0; i < 256; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
        do_write(32'h0, 255, 3'd2, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) ebuf[i] = 32'(i + 1);
        ar_phase(32'h0, 255, 3'd2, 2'b01, 1'b1);
        r_phase(255, 1'b1, 2'b00, 1'b0);

        // Fill the rest of memory so every word has a known value
        for (int blk = 1; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
            do_write(32'(blk * 1024), 255, 3'd2, 2'b01, 1'b1, 1'b0);
        end
        do_read(32'h400, 255, 3'd2, 2'b01, 1'b0, 1'b1);

        // Byte strobes
        wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
        do_write(32'h28, 0, 3'd2, 2'b01, 1'b0, 1'b0);
        wbuf[0] = 32'h0000_0000; sbuf[0] = 4'b0101;
        do_write(32'h28, 0, 3'd2, 2'b01, 1'b1, 1'b0);
        ebuf[0] = 32'hFF00_FF00;
        ar_phase(32'h28, 0, 3'd2, 2'b01, 1'b0);
        r_phase(0, 1'b0, 2'b00, 1'b0);

        // Out of range write leaves memory alone; FIXED read returns zeros
        wbuf[0] = 32'h1234_5678; wbuf[1] = 32'h9ABC_DEF0; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        do_write(32'(MEM_W * 4 - 4), 1, 3'd2, 2'b01, 1'b1, 1'b0);
        do_read(32'(MEM_W * 4 - 8), 1, 3'd2, 2'b01, 1'b0, 1'b0);
        do_read(32'h100, 3, 3'd2, 2'b00, 1'b1, 1'b1);

        // Early wlast on beat 2 of len=3, then late wlast on len=1
        for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        aw_phase(32'h200, 3, 3'd2, 2'b01, 1'b1);
        w_phase(2, 1, 1'b0);
        b_phase(1'b1, 2'b10, 1'b0);
        aw_phase(32'h200, 1, 3'd2, 2'b01, 1'b0);
        w_phase(3, 2, 1'b0);
        b_phase(1'b0, 2'b10, 1'b0);
        for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        do_write(32'h200, 3, 3'd2, 2'b01, 1'b0, 1'b0);
        do_read(32'h200, 3, 3'd2, 2'b01, 1'b1, 1'b0);

        // Simultaneous AW and AR, then concurrent data phases
        for (int i = 0; i < 8; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        for (int i = 0; i < 8; i++) ebuf[i] = model[100 + i];
        awvalid = 1'b1; awaddr = 32'h800; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01; awid = 1'b0;
        arvalid = 1'b1; araddr = 32'h190; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arid = 1'b1;
        @(negedge clk);
        check("aw_ar_same_cycle", 64'({awready, arready}), 64'(2'b11));
        @(posedge clk); #1;
        awvalid = 1'b0; arvalid = 1'b0;
        fork
            begin w_phase(8, 7, 1'b1); b_phase(1'b0, 2'b00, 1'b1); end
            r_phase(7, 1'b1, 2'b00, 1'b1);
        join
        for (int i = 0; i < 8; i++) model_beat(512 + i, wbuf[i], sbuf[i]);
        do_read(32'h800, 7, 3'd2, 2'b01, 1'b0, 1'b1);

        // Read and write of the same word on the same edge sees old data
        aw_phase(32'hC8, 0, 3'd2, 2'b01, 1'b1);
        ebuf[0] = model[50];
        wvalid = 1'b1; wdata = ~model[50]; wstrb = 4'hF; wlast = 1'b1;
        arvalid = 1'b1; araddr = 32'hC8; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arid = 1'b0;
        @(negedge clk);
        check("w_ar_same_cycle", 64'({wready, arready}), 64'(2'b11));
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        fork
            b_phase(1'b1, 2'b00, 1'b0);
            r_phase(0, 1'b0, 2'b00, 1'b0);
        join
        model_beat(50, wdata, 4'hF);
        do_read(32'hC8, 0, 3'd2, 2'b01, 1'b1, 1'b0);

        // Reset mid-burst: two beats land, burst abandoned
        for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom_range(1, 15)); end
        aw_phase(32'h320, 3, 3'd2, 2'b01, 1'b1);
        w_phase(2, -1, 1'b0);
        #1 xrst = 1'b1;
        #1;
        check("mid_reset_ready", 64'({awready, wready, bvalid, arready, rvalid, rlast}), 64'(6'b100100));
        check("mid_reset_regs", 64'({bresp, rresp, bid, rid, rdata}), 64'(0));
        @(posedge clk); #1;
        xrst = 1'b0;
        model_beat(200, wbuf[0], sbuf[0]);
        model_beat(201, wbuf[1], sbuf[1]);
        do_read(32'h320, 3, 3'd2, 2'b01, 1'b0, 1'b1);

        // Randomized bursts with stalls, odd burst types and sizes
        for (int it = 0; it < 24; it++) begin
            a   = 32'($urandom_range(0, MEM_W - 1)) << 2;
            ln  = $urandom_range(0, 15);
            case ($urandom_range(0, 7))
                0:       bt = 2'b00;
                1:       bt = 2'b10;
                default: bt = 2'b01;
            endcase
            sz  = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
            idv = 1'($urandom_range(0, 1));
            for (int i = 0; i <= ln; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom_range(0, 15)); end
            do_write(a, ln, sz, bt, idv, 1'b1);
            do_read(a, ln, 3'd2, 2'b01, ~idv, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
